// File: rtl/router_sync.sv
// Router synchronizer: latches the destination address, steers the FSM write strobe
// to one output FIFO, muxes that FIFO's full flag and runs per-port read timeouts.
module router_sync #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam int unsigned NPORT = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]                  addr_q, addr_d;
  logic [NPORT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NPORT-1:0]            sr_q, sr_d;
  logic [NPORT-1:0]            empty_v, read_v, stall;

  assign empty_v = {empty_2, empty_1, empty_0};
  assign read_v  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;
  assign stall     = ~empty_v & ~read_v;

  assign soft_reset_0 = sr_q[0];
  assign soft_reset_1 = sr_q[1];
  assign soft_reset_2 = sr_q[2];

  // Next-state: address capture and per-port stall counters.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    sr_d   = '0;
    if (detect_add) begin
      addr_d = data_in;
    end
    for (int i = 0; i < NPORT; i++) begin
      if (!stall[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i] = '0;
        sr_d[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q <= 2'b00;
      cnt_q  <= '0;
      sr_q   <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
    end
  end

  // Steering and full mux use the registered address; 11 selects nothing.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr_q)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/router_sync.md
# router_sync

Synchronizer and port controller between the router FSM and the three output FIFOs of the 1x3 router. It latches the destination address when the FSM decodes a header and steers the FSM's single write strobe to exactly one FIFO. It reports the addressed FIFO's full status back to the FSM and drives per-port valid outputs. It also runs three independent timeout counters that issue a one-cycle soft reset to any FIFO whose data is not read within the timeout window.

## Interface
Parameters:
- TIMEOUT, 30, consecutive stalled cycles before a port's soft reset fires; legal range 2..(2^CNT_W - 1)
- CNT_W, 5, width of each timeout counter

Ports:
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset, sampled on rising edge of clock
- detect_add  in  1  from FSM; latch data_in as destination address this edge
- data_in  in  2  destination address field of header byte (00/01/10 valid, 11 invalid)
- write_enb_reg  in  1  from FSM; write strobe for the currently addressed FIFO
- read_enb_0 / read_enb_1 / read_enb_2  in  1 each  read strobes from destination ports
- empty_0 / empty_1 / empty_2  in  1 each  FIFO empty flags
- full_0 / full_1 / full_2  in  1 each  FIFO full flags
- write_enb  out  3  one-hot FIFO write enable; bit i drives FIFO i
- fifo_full  out  1  to FSM; full flag of the addressed FIFO
- vld_out_0 / vld_out_1 / vld_out_2  out  1 each  port has data available
- soft_reset_0 / soft_reset_1 / soft_reset_2  out  1 each  registered one-cycle FIFO clear pulse

## Operation
Address register:
- addr (2 bits) loads data_in on any rising edge with detect_add=1 and resetn=1; otherwise holds.
- New addr is visible to combinational outputs from the cycle after the detect_add edge.

Write steering (combinational):
- write_enb = 3'b001 / 010 / 100 for addr 00 / 01 / 10 when write_enb_reg=1.
- write_enb = 000 when write_enb_reg=0 or addr=11.

Full mux (combinational):
- fifo_full = full_0 / full_1 / full_2 for addr 00 / 01 / 10.
- fifo_full = 0 for addr=11.

Valid (combinational):
- vld_out_i = ~empty_i.
- Independent of addr and reset state.

Timeout, per port i, independent:
- stall_i = vld_out_i & ~read_enb_i.
- On an edge with stall_i=0: cnt_i<=0, soft_reset_i<=0.
- On an edge with stall_i=1 and cnt_i < TIMEOUT-1: cnt_i<=cnt_i+1, soft_reset_i<=0.
- On an edge with stall_i=1 and cnt_i == TIMEOUT-1: cnt_i<=0, soft_reset_i<=1.
- If the stall persists after a pulse, counting restarts from 0 and another pulse follows after TIMEOUT more stalled edges.
- Counter arithmetic is unsigned CNT_W-bit and never wraps, because it is cleared at TIMEOUT-1.

Boundary conditions:
- detect_add and write_enb_reg high on the same edge: write_enb for that cycle uses the old addr.
- read_enb_i=1 on the edge where cnt_i==TIMEOUT-1: no pulse, cnt_i<=0.
- empty_i rising mid-count: cnt_i<=0, no pulse.
- Ports never interact; simultaneous pulses on several ports are legal.
- full_i toggling does not affect the counters.

## Timing
Reset (resetn=0 at a rising edge):
- addr<=00, cnt_0..2<=0, soft_reset_0..2<=0.
- Reset has priority over detect_add and over the counters, including when it is applied mid-count.
- Combinational outputs (write_enb, fifo_full, vld_out_*) follow their inputs during reset, using addr=00.

Latency:
- detect_add to steering: 1 cycle.
- write_enb_reg to write_enb: 0 cycles.
- full_i to fifo_full: 0 cycles.
- empty_i to vld_out_i: 0 cycles.
- soft_reset_i rises on the TIMEOUT-th consecutive stalled rising edge and is high for exactly one clock period.

## Test plan
- Reset, then detect_add=1 with data_in=01 for one edge, then write_enb_reg=1 -> write_enb=010. Set full_1=1 -> fifo_full=1. Set full_0=1, full_1=0 -> fifo_full=0.
- data_in=11 latched, write_enb_reg=1, full_0..2=111 -> write_enb=000, fifo_full=0.
- empty_0=0 and read_enb_0=0 held, TIMEOUT=30 -> soft_reset_0=0 through the 29th edge and 1 for exactly one cycle after the 30th edge. Keep stalling -> next pulse after the 60th edge.
- empty_2=0, stall for 29 edges, then read_enb_2=1 on the 30th edge -> no pulse. Resume stalling -> pulse only after 30 further stalled edges.
- Same-edge detect_add (data_in=10, prior addr=00) and write_enb_reg=1 -> write_enb=001 that cycle and 100 the next cycle.
- Port 1 stalled 20 edges, then resetn=0 for one edge, then stalled again -> pulse only after 30 new stalled edges. Addr reads back as 00 (write_enb=001 with write_enb_reg=1).
